// File: rtl/sram_mem_ctrl_if.sv
// Mem-stage data-memory request bus: the pipeline drives the request and
// freezes while ready is low.
interface sram_mem_ctrl_if #(
   parameter int WORD_WIDTH = 32
);
   logic                  mem_read;
   logic                  mem_write;
   logic [WORD_WIDTH-1:0] address;
   logic [WORD_WIDTH-1:0] write_data;
   logic [WORD_WIDTH-1:0] read_data;
   logic                  ready;

   modport master (
      output mem_read, mem_write, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  mem_read, mem_write, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Turns one 32-bit Mem-stage access into two 16-bit SRAM bus cycles (low half
// first) with programmable wait states, holding ready low until it completes.
//
//  state | meaning
//  IDLE  | no access in flight; accepts a request and latches it
//  LO    | low halfword bus cycle, WAIT_CYCLES+1 clocks
//  HI    | high halfword bus cycle, WAIT_CYCLES+1 clocks
//  DONE  | access complete, ready high for one clock
module sram_mem_ctrl #(
   parameter int WORD_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 18,
   parameter int SRAM_DATA_WIDTH = 16,
   parameter int WAIT_CYCLES     = 2,
   parameter int BASE_ADDR       = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   sram_mem_ctrl_if.slave             bus,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
   output logic                       sram_dq_oe,
   input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
   output logic                       sram_we_n,
   output logic                       sram_oe_n
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t                     state_q;
   state_t                     state_d;
   logic [CNT_W-1:0]           cnt_q;
   logic                       op_wr_q;
   logic [SRAM_ADDR_WIDTH-2:0] word_q;
   logic [WORD_WIDTH-1:0]      wdata_q;
   logic [WORD_WIDTH-1:0]      rdata_q;

   logic                       req;
   logic                       half_end;
   logic                       ready_c;
   logic [WORD_WIDTH-1:0]      addr_off;
   logic [SRAM_ADDR_WIDTH-2:0] addr_word;
   logic                       unused_addr_bits;

   assign req      = bus.mem_read | bus.mem_write;
   assign half_end = (cnt_q == '0);

   // Word index keeps only SRAM_ADDR_WIDTH-1 bits, so out-of-range addresses wrap.
   assign addr_off         = bus.address - WORD_WIDTH'(BASE_ADDR);
   assign addr_word        = addr_off[SRAM_ADDR_WIDTH:2];
   assign unused_addr_bits = ^{addr_off[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], addr_off[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ready_c     = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      case (state_q)
         S_IDLE: begin
            ready_c = ~req;
            if (req) begin
               state_d = S_LO;
            end
         end
         S_LO: begin
            sram_addr = {word_q, 1'b0};
            if (op_wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[SRAM_DATA_WIDTH-1:0];
               // Release we_n one clock early so data is held past the strobe.
               sram_we_n   = half_end;
            end else begin
               sram_oe_n = 1'b0;
            end
            if (half_end) begin
               state_d = S_HI;
            end
         end
         S_HI: begin
            sram_addr = {word_q, 1'b1};
            if (op_wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[WORD_WIDTH-1:SRAM_DATA_WIDTH];
               sram_we_n   = half_end;
            end else begin
               sram_oe_n = 1'b0;
            end
            if (half_end) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            ready_c = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  op_wr_q <= bus.mem_write;
                  word_q  <= addr_word;
                  wdata_q <= bus.write_data;
                  cnt_q   <= CNT_W'(WAIT_CYCLES);
               end
            end
            S_LO: begin
               if (half_end) begin
                  cnt_q <= CNT_W'(WAIT_CYCLES);
                  if (!op_wr_q) begin
                     rdata_q[SRAM_DATA_WIDTH-1:0] <= sram_dq_in;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_HI: begin
               if (half_end) begin
                  if (!op_wr_q) begin
                     rdata_q[WORD_WIDTH-1:SRAM_DATA_WIDTH] <= sram_dq_in;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready     = ready_c;
   assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: directed scenarios plus random accesses against a
// halfword-array reference model and a behavioural SRAM.
module tb_sram_mem_ctrl;

   localparam int WAIT = 2;
   localparam int BASE = 1024;
   // Edges counted from the accepting edge up to the first cycle with ready=1.
   localparam int LAT  = 2 * WAIT + 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic        sram_oe_n;

   always #5 clk = ~clk;

   sram_mem_ctrl_if bus ();

   sram_mem_ctrl #(
      .WORD_WIDTH(32), .SRAM_ADDR_WIDTH(18), .SRAM_DATA_WIDTH(16),
      .WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_in (sram_dq_in),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n)
   );

   // Behavioural asynchronous SRAM plus bus activity monitors.
   logic [15:0] sram [0:262143];
   logic [33:0] wr_log [$];
   int          oe_cycles = 0;
   int          strobes   = 0;
   logic        prev_we   = 1'b1;

   assign sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr];

   always @(negedge clk) begin
      if (!sram_we_n && sram_dq_oe) begin
         sram[sram_addr] <= sram_dq_out;
         wr_log.push_back({sram_addr, sram_dq_out});
      end
      if (!sram_oe_n) oe_cycles <= oe_cycles + 1;
      if (!sram_we_n && prev_we) strobes <= strobes + 1;
      prev_we <= sram_we_n;
   end

   // Reference model: halfword store and last-read value.
   logic [15:0] ref_mem [int];
   logic [31:0] exp_rdata = 32'h0;
   int          n_assert  = 0;
   int          n_fail    = 0;

   function automatic int hw_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'(BASE);
      return int'((off / 32'd4) % 32'd131072) * 2;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output int edges);
      bus.mem_read   = rd;
      bus.mem_write  = wr;
      bus.address    = a;
      bus.write_data = d;
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!bus.ready && edges < 50);
   endtask

   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int extra, input string tag);
      int e;
      int h;
      h = hw_of(a);
      access(rd, wr, a, d, e);
      check({tag, "_lat"}, 64'(e), 64'(LAT + extra));
      if (wr) begin
         ref_mem[h]     = d[15:0];
         ref_mem[h + 1] = d[31:16];
         check({tag, "_mem_lo"}, 64'(sram[h]), 64'(ref_mem[h]));
         check({tag, "_mem_hi"}, 64'(sram[h + 1]), 64'(ref_mem[h + 1]));
      end else begin
         exp_rdata = {ref_mem[h + 1], ref_mem[h]};
      end
      check({tag, "_rdata"}, 64'(bus.read_data), 64'(exp_rdata));
   endtask

   task automatic go_idle(input int n);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      int oe0;
      int st0;
      bit in_done;

      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.address    = 32'h0;
      bus.write_data = 32'h0;

      // Reset state
      #2;
      check("rst_ready", 64'(bus.ready), 64'd1);
      check("rst_we_n", 64'(sram_we_n), 64'd1);
      check("rst_oe_n", 64'(sram_oe_n), 64'd1);
      check("rst_dq_oe", 64'(sram_dq_oe), 64'd0);
      check("rst_addr", 64'(sram_addr), 64'd0);
      check("rst_dq_out", 64'(sram_dq_out), 64'd0);
      check("rst_rdata", 64'(bus.read_data), 64'd0);
      #10 rst = 1'b1;
      @(posedge clk);
      #1;

      // Word write: two halves, we_n low two cycles each
      idx = wr_log.size();
      do_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 0, "wr1032");
      check("wr_log_len", 64'(wr_log.size() - idx), 64'd4);
      if (wr_log.size() - idx == 4) begin
         check("wr_log0", 64'(wr_log[idx]),     {30'h0, 18'd4, 16'hBEEF});
         check("wr_log1", 64'(wr_log[idx + 1]), {30'h0, 18'd4, 16'hBEEF});
         check("wr_log2", 64'(wr_log[idx + 2]), {30'h0, 18'd5, 16'hDEAD});
         check("wr_log3", 64'(wr_log[idx + 3]), {30'h0, 18'd5, 16'hDEAD});
      end
      go_idle(1);
      check("idle_ready", 64'(bus.ready), 64'd1);

      // Read back; oe_n low for 2*(WAIT+1) cycles
      oe0 = oe_cycles;
      do_op(1'b1, 1'b0, 32'd1032, 32'h0, 0, "rd1032");
      check("rd_value", 64'(bus.read_data), 64'hDEADBEEF);
      check("rd_oe_cycles", 64'(oe_cycles - oe0), 64'd6);
      go_idle(1);

      // Reset in the middle of a read
      bus.mem_read = 1'b1;
      bus.address  = 32'd1036;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("midrd_oe_active", 64'(sram_oe_n), 64'd0);
      #2 rst = 1'b0;
      #1;
      check("midrd_we_n", 64'(sram_we_n), 64'd1);
      check("midrd_oe_n", 64'(sram_oe_n), 64'd1);
      check("midrd_dq_oe", 64'(sram_dq_oe), 64'd0);
      check("midrd_rdata", 64'(bus.read_data), 64'd0);
      exp_rdata = 32'h0;
      bus.mem_read = 1'b0;
      #1;
      check("midrd_ready", 64'(bus.ready), 64'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Write then back-to-back read of the same word
      st0 = strobes;
      do_op(1'b0, 1'b1, 32'd1036, 32'h12345678, 0, "wr1036");
      do_op(1'b1, 1'b0, 32'd1036, 32'h0, 1, "b2b_rd1036");
      check("b2b_strobes", 64'(strobes - st0), 64'd2);
      go_idle(1);

      // Read and write together behave as a write
      do_op(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 0, "rdwr1024");
      check("rdwr_keep_rdata", 64'(bus.read_data), 64'h12345678);
      go_idle(1);

      // Reset during the high half of a write
      bus.mem_write  = 1'b1;
      bus.address    = 32'd1032;
      bus.write_data = 32'hCAFEF00D;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("midwr_hi_addr", 64'(sram_addr), 64'd5);
      check("midwr_hi_we", 64'(sram_we_n), 64'd0);
      #1 rst = 1'b0;
      #1;
      check("midwr_we_n", 64'(sram_we_n), 64'd1);
      check("midwr_dq_oe", 64'(sram_dq_oe), 64'd0);
      check("midwr_oe_n", 64'(sram_oe_n), 64'd1);
      ref_mem[4] = 16'hF00D;
      exp_rdata  = 32'h0;
      bus.mem_write = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("midwr_lo_done", 64'(sram[4]), 64'hF00D);
      check("midwr_hi_kept", 64'(sram[5]), 64'hDEAD);
      do_op(1'b1, 1'b0, 32'd1032, 32'h0, 0, "after_rst_rd");
      go_idle(1);

      // Random traffic, including wrapping addresses and back-to-back requests
      in_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         int          v;
         int          op;
         int          extra;
         bit          rd;
         bit          wr;
         v = $urandom_range(0, 3);
         a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         if (v == 2) a = a + 32'h0008_0000;
         if (v == 3) a = 32'(BASE - 4) + 32'($urandom_range(0, 3));
         d  = $urandom;
         op = $urandom_range(0, 2);
         if (!ref_mem.exists(hw_of(a))) op = 1;
         rd = (op != 1);
         wr = (op != 0);
         extra = 0;
         if (in_done && $urandom_range(0, 1) == 1) begin
            extra = 1;
         end else if (in_done) begin
            go_idle($urandom_range(1, 3));
         end
         do_op(rd, wr, a, d, extra, $sformatf("rnd%0d", i));
         in_done = 1'b1;
      end
      go_idle(2);
      check("final_ready", 64'(bus.ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
